// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and helpers for the pipeline hazard scoreboard.
package mips_pipe_pkg;

  // Entries store rd at this fixed width; REG_AW must not exceed it.
  localparam int unsigned RegAwMax = 8;

  // Forwarding select code meaning "use the register file value".
  localparam int unsigned SEL_RF = 0;

  typedef struct packed {
    logic                valid;
    logic [RegAwMax-1:0] rd;
    logic                is_load;
  } sb_entry_t;

  // Ceiling log2, never less than 1 so it can size a vector.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage <-> hazard scoreboard signal bundle.
interface hazard_scoreboard_if
  import mips_pipe_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned SEL_W = clog2(DEPTH + 1);

  logic              hold;
  logic              flush;
  logic              id_valid;
  logic              id_we;
  logic [REG_AW-1:0] id_rd;
  logic              id_is_load;
  logic              id_use_a;
  logic [REG_AW-1:0] id_rs_a;
  logic              id_use_b;
  logic [REG_AW-1:0] id_rs_b;
  logic              stall;
  logic              issue;
  logic [SEL_W-1:0]  fwd_sel_a;
  logic [SEL_W-1:0]  fwd_sel_b;
  logic [CNT_W-1:0]  stall_cnt;

  // Pipeline control side: drives ID info, consumes hazard decisions.
  modport master (
    output hold, flush, id_valid, id_we, id_rd, id_is_load,
           id_use_a, id_rs_a, id_use_b, id_rs_b,
    input  stall, issue, fwd_sel_a, fwd_sel_b, stall_cnt
  );

  // Scoreboard side.
  modport slave (
    input  hold, flush, id_valid, id_we, id_rd, id_is_load,
           id_use_a, id_rs_a, id_use_b, id_rs_b,
    output stall, issue, fwd_sel_a, fwd_sel_b, stall_cnt
  );

endinterface

// File: rtl/hazard_scoreboard_match.sv
// Per-source scan: finds the youngest in-flight writer of rs and whether
// its result can already be forwarded.
module sb_match
  import mips_pipe_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned ALU_READY  = 0,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned SEL_W      = 2
) (
  input  sb_entry_t [DEPTH-1:0] entries_i,
  input  logic                  use_i,
  input  logic [REG_AW-1:0]     rs_i,
  output logic                  hit_o,
  output logic [SEL_W-1:0]      sel_o,
  output logic                  ready_o
);

  logic [RegAwMax-1:0] rs_ext;
  assign rs_ext = RegAwMax'(rs_i);

  // Lowest index (youngest) match wins; ready is only meaningful on a hit.
  always_comb begin
    hit_o   = 1'b0;
    sel_o   = SEL_W'(SEL_RF);
    ready_o = 1'b1;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!hit_o && use_i && (rs_i != '0) && entries_i[i].valid &&
          (entries_i[i].rd == rs_ext)) begin
        hit_o   = 1'b1;
        sel_o   = SEL_W'(i + 1);
        ready_o = (i >= (entries_i[i].is_load ? LOAD_READY : ALU_READY));
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard of in-flight register writers after ID.
// Produces forwarding selects, load-use stall/issue and a stall counter.
module hazard_scoreboard
  import mips_pipe_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned ALU_READY  = 0,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned CNT_W      = 16
) (
  input logic                clk,
  input logic                reset,
  hazard_scoreboard_if.slave sb_io
);

  localparam int unsigned SEL_W = clog2(DEPTH + 1);

  sb_entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

  logic             hit_a, hit_b, ready_a, ready_b;
  logic [SEL_W-1:0] sel_a, sel_b;
  logic             stall, issue;

  sb_match #(
    .REG_AW    (REG_AW),
    .DEPTH     (DEPTH),
    .ALU_READY (ALU_READY),
    .LOAD_READY(LOAD_READY),
    .SEL_W     (SEL_W)
  ) u_match_a (
    .entries_i(entries_q),
    .use_i    (sb_io.id_use_a),
    .rs_i     (sb_io.id_rs_a),
    .hit_o    (hit_a),
    .sel_o    (sel_a),
    .ready_o  (ready_a)
  );

  sb_match #(
    .REG_AW    (REG_AW),
    .DEPTH     (DEPTH),
    .ALU_READY (ALU_READY),
    .LOAD_READY(LOAD_READY),
    .SEL_W     (SEL_W)
  ) u_match_b (
    .entries_i(entries_q),
    .use_i    (sb_io.id_use_b),
    .rs_i     (sb_io.id_rs_b),
    .hit_o    (hit_b),
    .sel_o    (sel_b),
    .ready_o  (ready_b)
  );

  // Stall/issue decision; flush and hold both override a hazard.
  always_comb begin
    stall = sb_io.id_valid && !sb_io.flush && !sb_io.hold &&
            ((hit_a && !ready_a) || (hit_b && !ready_b));
    issue = sb_io.id_valid && !stall && !sb_io.flush && !sb_io.hold;
  end

  // Next state: shift entries, load entry 0 (bubble unless issued), count stalls.
  always_comb begin
    entries_d   = entries_q;
    stall_cnt_d = stall_cnt_q;
    if (!sb_io.hold) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        entries_d[i] = entries_q[i-1];
      end
      entries_d[0].valid   = issue && sb_io.id_we && (sb_io.id_rd != '0);
      entries_d[0].rd      = RegAwMax'(sb_io.id_rd);
      entries_d[0].is_load = sb_io.id_is_load;
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entries_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      entries_q   <= entries_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign sb_io.stall     = stall;
  assign sb_io.issue     = issue;
  assign sb_io.fwd_sel_a = sel_a;
  assign sb_io.fwd_sel_b = sel_b;
  assign sb_io.stall_cnt = stall_cnt_q;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed forwarding/hazard logic of the 5-stage MIPS pipeline.
- Tracks in-flight register writers across DEPTH post-decode stages in a shift-register scoreboard.
- From that state it generates per-source forwarding selects, load-use stall, bubble insertion and a stall performance counter.
- Sits beside the ID stage and replaces per-case hand-coded forward muxes with depth- and latency-generic selection.

Parameters:
REG_AW, 5, register address width (2**REG_AW architectural registers; register 0 hard-wired zero)
DEPTH, 3, tracked stages after ID (entry 0 = EX, 1 = MEM, 2 = WB)
ALU_READY, 0, lowest entry index at which a non-load result is forwardable
LOAD_READY, 2, lowest entry index at which load data is forwardable
CNT_W, 16, stall counter width
SEL_W, clog2(DEPTH+1), forwarding select width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-low reset
hold  in  1  global freeze (e.g. multi-cycle memory); no state change while high
flush  in  1  branch/jump taken in EX; discard instruction in ID
id_valid  in  1  ID holds a valid instruction
id_we  in  1  ID instruction writes a register
id_rd  in  REG_AW  ID destination register
id_is_load  in  1  ID instruction is a load
id_use_a  in  1  ID reads source A
id_rs_a  in  REG_AW  source A register
id_use_b  in  1  ID reads source B
id_rs_b  in  REG_AW  source B register
stall  out  1  hold PC and IF/ID register, insert bubble into EX
issue  out  1  ID instruction enters EX this cycle
fwd_sel_a  out  SEL_W  0 = register file, k = result of entry k-1
fwd_sel_b  out  SEL_W  same encoding for source B
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Entry state per index i: valid, rd, is_load. Entry i is ready when i >= (is_load ? LOAD_READY : ALU_READY).
- Match rule: a source matches entry i when valid & rd == rs & rs != 0 & use. The youngest matching entry (lowest index) wins.
- fwd_sel = index+1 of the winning entry, else 0. All outputs are combinational from entries and inputs; zero-latency decision.
- stall = id_valid & ~flush & ~hold & (either source's winning entry is not ready).
- issue = id_valid & ~stall & ~flush & ~hold.
- Clock edge with hold=0:
  - Entries shift, i → i+1; entry DEPTH-1 is retired, since the register file is written at that edge.
  - Entry 0 loads {issue & id_we & id_rd != 0, id_rd, id_is_load}. A stall or flush therefore inserts a bubble.
- Clock edge with hold=1: all state and stall_cnt hold; stall=0 and issue=0 during hold.
- stall_cnt increments on each clocked cycle with stall=1 and saturates at all-ones.
- Entry DEPTH-1 (write-back) is still forwarded (sel=DEPTH), covering same-cycle write/read.
- Flush and hazard in the same cycle: flush wins. stall=0, the ID instruction is dropped, a bubble is inserted, and the counter is unchanged. Entry 0 (the branch itself) is not killed.
- Reset asserted (async, any time, including mid-stall): all entries invalid and stall_cnt=0. Outputs then resolve to stall=0 and fwd_sel=0 for any inputs; issue=id_valid&~flush&~hold.
- Reset release is synchronous to clk via the existing reset synchroniser upstream.

Decomposition:
- Package mips_pipe_pkg holds:
  - the clog2 function;
  - SEL_RF=0, the register-file select code;
  - the scoreboard entry struct {valid, rd, is_load}.
- One sub-module, sb_match: for one source, scans DEPTH entries and returns hit, sel and ready. It is instantiated twice (A, B).
- The top holds the entry shift register, stall/issue logic and counter.

Test Plan:
- Reset: pulse reset low mid-run with entries valid → stall=0, fwd_sel_a=fwd_sel_b=0, stall_cnt=0, immediately (async).
- ALU back-to-back: issue add $3; next cycle ID reads $3 on A → fwd_sel_a=1, stall=0. A third-cycle reader of $3 → fwd_sel_a=2.
- Load-use (defaults): issue lw $4; next ID reads $4 on B → stall=1 for exactly 2 cycles, then fwd_sel_b=3, issue=1, stall_cnt=2.
- Youngest wins / $0: writers to $5 in entries 1 and 0, ID reads $5 → sel=1. Writers to $0 with ID reading $0 → sel=0, stall=0.
- Flush during stall: load-use stall active, assert flush → stall=0, issue=0, bubble in entry 0, stall_cnt unchanged.
- Hold: assert hold for 3 cycles during a load-use stall → entries and stall_cnt frozen. After release, stall resumes its remaining count.
